// File: rtl/lcd_timing_pkg.sv
// Shared widths, default 800x480 panel timing and the colour-bar table for the LCD timing driver.
package lcd_timing_pkg;

  localparam int unsigned RGB_W   = 24;
  localparam int unsigned POS_W   = 11;
  localparam int unsigned POS_MAX = 2047;

  localparam int unsigned H_SYNC_DEF  = 128;
  localparam int unsigned H_BACK_DEF  = 88;
  localparam int unsigned H_DISP_DEF  = 800;
  localparam int unsigned H_FRONT_DEF = 40;
  localparam int unsigned V_SYNC_DEF  = 2;
  localparam int unsigned V_BACK_DEF  = 33;
  localparam int unsigned V_DISP_DEF  = 480;
  localparam int unsigned V_FRONT_DEF = 10;

  typedef logic [POS_W-1:0] pos_t;

  // Eight equal vertical bars, left to right.
  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// Wrapping scan counter for one display axis; wrap flags the increment that returns it to zero.
module lcd_axis_counter
  import lcd_timing_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [POS_W-1:0] max,
  output logic [POS_W-1:0] cnt,
  output logic             wrap
);

  pos_t cnt_q, cnt_d;

  assign wrap = inc && (cnt_q == max);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_timing_driver.sv
// RGB LCD timing generator: scan counters, pixel request, and registered HS/VS/DE/RGB to the panel.
// Defining LCD_TEST_PATTERN_EN adds a test_en input that swaps pixel_data for 8 colour bars.
module lcd_timing_driver
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC  = H_SYNC_DEF,
  parameter int unsigned H_BACK  = H_BACK_DEF,
  parameter int unsigned H_DISP  = H_DISP_DEF,
  parameter int unsigned H_FRONT = H_FRONT_DEF,
  parameter int unsigned V_SYNC  = V_SYNC_DEF,
  parameter int unsigned V_BACK  = V_BACK_DEF,
  parameter int unsigned V_DISP  = V_DISP_DEF,
  parameter int unsigned V_FRONT = V_FRONT_DEF
) (
  input  logic             lcd_pclk,
  input  logic             rst_n,
  input  logic [RGB_W-1:0] pixel_data,
`ifdef LCD_TEST_PATTERN_EN
  input  logic             test_en,
`endif
  output logic             data_req,
  output logic [POS_W-1:0] pixel_xpos,
  output logic [POS_W-1:0] pixel_ypos,
  output logic [POS_W-1:0] h_disp,
  output logic [POS_W-1:0] v_disp,
  output logic             frame_done,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [RGB_W-1:0] lcd_rgb
);

  localparam int unsigned H_TOT   = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOT   = V_SYNC + V_BACK + V_DISP + V_FRONT;
  // Request window opens one pixel early so the registered source data meets lcd_de.
  localparam int unsigned H_ACT_S = H_SYNC + H_BACK - 1;
  localparam int unsigned H_ACT_E = H_ACT_S + H_DISP;
  localparam int unsigned V_ACT_S = V_SYNC + V_BACK;
  localparam int unsigned V_ACT_E = V_ACT_S + V_DISP;

  if (H_TOT > POS_MAX) begin : g_h_tot_chk
    $error("lcd_timing_driver: H_TOT=%0d does not fit the 11-bit counter", H_TOT);
  end
  if (V_TOT > POS_MAX) begin : g_v_tot_chk
    $error("lcd_timing_driver: V_TOT=%0d does not fit the 11-bit counter", V_TOT);
  end

  pos_t h_cnt, v_cnt;
  logic h_wrap, v_wrap;
  logic h_act, v_act;
  logic hs_q, vs_q, de_q;

  lcd_axis_counter u_h_cnt (
    .clk   (lcd_pclk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .max   (POS_W'(H_TOT - 1)),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  lcd_axis_counter u_v_cnt (
    .clk   (lcd_pclk),
    .rst_n (rst_n),
    .inc   (h_wrap),
    .max   (POS_W'(V_TOT - 1)),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  assign h_act      = (h_cnt >= POS_W'(H_ACT_S)) && (h_cnt < POS_W'(H_ACT_E));
  assign v_act      = (v_cnt >= POS_W'(V_ACT_S)) && (v_cnt < POS_W'(V_ACT_E));
  assign data_req   = h_act && v_act;
  assign pixel_xpos = data_req ? h_cnt - POS_W'(H_ACT_S) : '0;
  assign pixel_ypos = data_req ? v_cnt - POS_W'(V_ACT_S) : '0;
  assign h_disp     = POS_W'(H_DISP);
  assign v_disp     = POS_W'(V_DISP);
  // v_wrap only fires on the last pixel of the last line.
  assign frame_done = v_wrap;

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      de_q <= 1'b0;
    end else begin
      hs_q <= (h_cnt >= POS_W'(H_SYNC));
      vs_q <= (v_cnt >= POS_W'(V_SYNC));
      de_q <= data_req;
    end
  end

  assign lcd_hs = hs_q;
  assign lcd_vs = vs_q;
  assign lcd_de = de_q;

  // pixel_data is registered at the source, so gating it with the DE flop keeps both aligned.
`ifdef LCD_TEST_PATTERN_EN
  logic [RGB_W-1:0] bar_q;
  logic [2:0]       bar_idx;

  assign bar_idx = 3'((32'(pixel_xpos) * 32'd8) / H_DISP);

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      bar_q <= '0;
    end else begin
      bar_q <= bar_colour(bar_idx);
    end
  end

  assign lcd_rgb = !de_q ? '0 : (test_en ? bar_q : pixel_data);
`else
  assign lcd_rgb = de_q ? pixel_data : '0;
`endif

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Directed bench for lcd_timing_driver on a 15x8 total (8x4 active) timing.
module tb_lcd_timing_driver;

  localparam int HS = 2, HB = 3, HD = 8, HF = 2;
  localparam int VS = 1, VB = 2, VD = 4, VF = 1;
  localparam int HT = 15, VT = 8;
  localparam int X0 = 4, Y0 = 3;  // first requested h_cnt / v_cnt

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pixel_data;
  logic        data_req, frame_done, lcd_hs, lcd_vs, lcd_de;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic [23:0] lcd_rgb;
`ifdef LCD_TEST_PATTERN_EN
  logic        test_en = 1'b0;
`endif

  lcd_timing_driver #(
    .H_SYNC (HS), .H_BACK (HB), .H_DISP (HD), .H_FRONT (HF),
    .V_SYNC (VS), .V_BACK (VB), .V_DISP (VD), .V_FRONT (VF)
  ) dut (
    .lcd_pclk   (clk),
    .rst_n      (rst_n),
    .pixel_data (pixel_data),
`ifdef LCD_TEST_PATTERN_EN
    .test_en    (test_en),
`endif
    .data_req   (data_req),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .h_disp     (h_disp),
    .v_disp     (v_disp),
    .frame_done (frame_done),
    .lcd_hs     (lcd_hs),
    .lcd_vs     (lcd_vs),
    .lcd_de     (lcd_de),
    .lcd_rgb    (lcd_rgb)
  );

  always #5 clk = ~clk;

  // Pixel source: registers {ypos, xpos} one cycle after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pixel_data <= '0;
    else        pixel_data <= {2'b00, pixel_ypos, pixel_xpos};
  end

  int          n_chk = 0;
  int          n_fail = 0;
  int          mh, mv;
  logic        e_hs, e_vs, e_de, tp;
  logic [23:0] e_rgb;
  logic [23:0] bars [8];

  function automatic logic f_req(int h, int v);
    return (h >= X0) && (h < X0 + HD) && (v >= Y0) && (v < Y0 + VD);
  endfunction

  function automatic logic [23:0] f_pix(int h, int v);
    if (!f_req(h, v)) return 24'h0;
    return {2'b00, 11'(v - Y0), 11'(h - X0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = '0;
  endtask

  task automatic check_all();
    logic [23:0] p;
    p = f_pix(mh, mv);
    chk("data_req", 32'(data_req), 32'(f_req(mh, mv)));
    chk("pixel_xpos", 32'(pixel_xpos), 32'(p[10:0]));
    chk("pixel_ypos", 32'(pixel_ypos), 32'(p[21:11]));
    chk("frame_done", 32'(frame_done), 32'((mh == HT - 1) && (mv == VT - 1)));
    chk("lcd_hs", 32'(lcd_hs), 32'(e_hs));
    chk("lcd_vs", 32'(lcd_vs), 32'(e_vs));
    chk("lcd_de", 32'(lcd_de), 32'(e_de));
    chk("lcd_rgb", 32'(lcd_rgb), 32'(e_rgb));
  endtask

  task automatic step();
    @(posedge clk);
    e_hs  = (mh >= HS);
    e_vs  = (mv >= VS);
    e_de  = f_req(mh, mv);
    e_rgb = !e_de ? 24'h0 : (tp ? bars[mh - X0] : f_pix(mh, mv));
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    #1;
    check_all();
  endtask

  initial begin
    int   de_n, rises, fd_n, k;
    logic de_last;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    tp = 1'b0;
    model_reset();

    // Reset state, then the idle half-cycle after release.
    repeat (3) @(negedge clk);
    check_all();
    chk("h_disp", 32'(h_disp), 32'd8);
    chk("v_disp", 32'(v_disp), 32'd4);
    rst_n = 1'b1;
    #1;
    check_all();

    // First frame: per-cycle checks plus DE and frame_done counts.
    de_n = 0; rises = 0; fd_n = 0; de_last = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      step();
      if (lcd_de) de_n++;
      if (lcd_de && !de_last) rises++;
      de_last = lcd_de;
      if (frame_done) fd_n++;
    end
    chk("de cycles per frame", 32'(de_n), 32'd32);
    chk("de lines per frame", 32'(rises), 32'd4);
    chk("frame_done per frame", 32'(fd_n), 32'd1);
    step();
    chk("lcd_vs low after wrap", 32'(lcd_vs), 32'd0);

    // Second frame, into the mid-frame reset point v=4, h=6.
    k = 0;
    while (!((mv == 4) && (mh == 6)) && k < 300) begin
      step();
      k++;
    end
    chk("reached v4 h6", 32'(k < 300), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst data_req", 32'(data_req), 32'd0);
    chk("rst pixel_xpos", 32'(pixel_xpos), 32'd0);
    chk("rst pixel_ypos", 32'(pixel_ypos), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    chk("rst lcd_hs", 32'(lcd_hs), 32'd1);
    chk("rst lcd_vs", 32'(lcd_vs), 32'd1);
    chk("rst lcd_de", 32'(lcd_de), 32'd0);
    chk("rst lcd_rgb", 32'(lcd_rgb), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();

    // Release cycle counts as cycle 1, so frame_done lands in cycle 120.
    k = 1;
    do begin
      step();
      k++;
    end while (!frame_done && k < 250);
    chk("first frame_done cycle", 32'(k), 32'd120);
    k = 0;
    do begin
      step();
      k++;
    end while (!frame_done && k < 250);
    chk("frame_done period", 32'(k), 32'd120);

`ifdef LCD_TEST_PATTERN_EN
    // DE is low at the frame end, so the pattern can switch in cleanly.
    test_en = 1'b1;
    tp = 1'b1;
    for (int i = 0; i < 120; i++) step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
